// File: rtl/jtopl_slot_reg_pkg.sv
// Shared definitions for the per-slot parameter store and its slot counter.
package jtopl_slot_reg_pkg;

  localparam int SLOT_W     = 5;
  localparam int DEF_STAGES = 18;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_BUSY = 1'b1
  } wr_state_t;

  // A 5-bit counter cannot address more than 32 slots; fewer than 3 breaks the ring.
  function automatic bit stages_ok(input int n);
    return (n > 2) && (n <= 32);
  endfunction

endpackage

// File: rtl/jtopl_slot_cnt.sv
// Slot counter with a revolution marker; shared by the operator pipeline stages.
module jtopl_slot_cnt
  import jtopl_slot_reg_pkg::*;
#(
  parameter int STAGES = DEF_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  output logic [SLOT_W-1:0] slot,
  output logic              zero
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(STAGES - 1);

  if (!stages_ok(STAGES)) begin : g_stages_chk
    $error("jtopl_slot_cnt: STAGES must be within 3..32");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      zero <= 1'b1;
    end else if (cen) begin
      if (slot == LAST) begin
        slot <= '0;
        zero <= 1'b1;
      end else begin
        slot <= slot + 1'b1;
        zero <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtopl_slot_reg.sv
// Per-slot parameter ring, time-aligned with the slot counter, with single-value write injection.
module jtopl_slot_reg
  import jtopl_slot_reg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = DEF_STAGES,
  parameter int RSTVAL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              wr_req,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_busy,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [SLOT_W-1:0] slot,
  output logic              zero,
  output logic [WIDTH-1:0]  dout
);

  localparam logic             RST_BIT  = 1'(RSTVAL);
  localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RST_BIT}};
  localparam logic [SLOT_W:0]  NSLOTS   = (SLOT_W + 1)'(STAGES);

  if (!stages_ok(STAGES)) begin : g_stages_chk
    $error("jtopl_slot_reg: STAGES must be within 3..32");
  end

  wr_state_t         st;
  logic [SLOT_W-1:0] wr_slot_q;
  logic [WIDTH-1:0]  wr_data_q;
  logic [WIDTH-1:0]  ring [STAGES];
  logic              slot_ok;
  logic              inject;

  jtopl_slot_cnt #(.STAGES(STAGES)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .slot  (slot),
    .zero  (zero)
  );

  assign slot_ok = {1'b0, wr_slot} < NSLOTS;
  assign inject  = (st == WR_BUSY) && (slot == wr_slot_q);
  assign wr_busy = (st == WR_BUSY);
  assign dout    = ring[0];

  // Head recirculates to the tail unless the pending write targets the slot leaving now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) ring[i] <= RST_WORD;
    end else if (cen) begin
      for (int i = 0; i < STAGES - 1; i++) ring[i] <= ring[i+1];
      ring[STAGES-1] <= inject ? wr_data_q : ring[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= WR_IDLE;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      case (st)
        WR_IDLE: begin
          if (wr_req) begin
            if (slot_ok) st <= WR_BUSY;
            else         wr_err <= 1'b1;
          end
        end
        WR_BUSY: begin
          if (cen && inject) begin
            st     <= WR_IDLE;
            wr_ack <= 1'b1;
          end
        end
        default: st <= WR_IDLE;
      endcase
    end
  end

  // Latched write is captured only from idle, so a busy store never loses its data.
  always_ff @(posedge clk) begin
    if (st == WR_IDLE && wr_req && slot_ok) begin
      wr_slot_q <= wr_slot;
      wr_data_q <= wr_data;
    end
  end

endmodule
